// File: rtl/wb_ext_mem_arbiter.sv
// Two-master, one-slave Wishbone B3 round-robin arbiter for the external
// memory port. Master 0 is the CPU path; master 1 is a second bus master
// such as VGA fetch or DMA. A grant is held for a whole CYC, so bursts
// pass through intact.
//
// Build option: define WB_ARB_TIMEOUT_EN to add a watchdog. It aborts a
// slave access that sees no termination for TIMEOUT_CYCLES clocks.
//
// Ports:
//   wb_clk_i, wb_rst_n_i            clock, async active-low reset
//   mN_adr/dat/sel/we/cyc/stb/cti/bte_i   master N request (N=0,1)
//   mN_dat/ack/err/rty_o            master N response
//   s_adr/dat/sel/we/cyc/stb/cti/bte_o    slave request
//   s_dat/ack/err/rty_i             slave response
//   gnt_o                           one-hot current grant (debug)
module wb_ext_mem_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,

    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic [2:0]        m0_cti_i,
    input  logic [1:0]        m0_bte_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_rty_o,

    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic [2:0]        m1_cti_i,
    input  logic [1:0]        m1_bte_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_rty_o,

    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic [2:0]        s_cti_o,
    output logic [1:0]        s_bte_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,

    output logic [1:0]        gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
        ,
        ABORT = 2'd3
`endif
    } state_t;

    state_t state, state_next;
    logic   last, last_next;
    logic   sel1_c;
    logic   abort_err_c;
    logic   timeout_hit_c;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          abort_first;
    logic          counting_c;

    // A beat is outstanding while the slave sees STB without any termination.
    assign counting_c    = s_stb_o & ~s_ack_i & ~s_err_i & ~s_rty_i;
    assign timeout_hit_c = counting_c && (cnt == CW'(TIMEOUT_CYCLES - 1));
    // The owner of an aborted access is the master last granted.
    assign sel1_c        = (state == GNT1) || ((state == ABORT) && last);
    assign abort_err_c   = (state == ABORT) && abort_first;

    // Watchdog counter and one-shot marker for the first ABORT cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cnt         <= '0;
            abort_first <= 1'b0;
        end else begin
            abort_first <= (state_next == ABORT) && (state != ABORT);
            if ((state == IDLE) || (state_next != state) || s_ack_i || s_err_i || s_rty_i) begin
                cnt <= '0;
            end else if (counting_c) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
`else
    assign timeout_hit_c = 1'b0;
    assign sel1_c        = (state == GNT1);
    assign abort_err_c   = 1'b0;
`endif

    // State, round-robin pointer and registered grant vector.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            last  <= 1'b1;
            gnt_o <= 2'b00;
        end else begin
            state <= state_next;
            last  <= last_next;
            gnt_o <= {state_next == GNT1, state_next == GNT0};
        end
    end

    // Next-state: hold the grant for the whole CYC, hand over without an
    // idle cycle when the other master is already waiting.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_next = m1_cyc_i ? GNT1 : IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit_c) begin
                    state_next = ABORT;
                end
`endif
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_next = m0_cyc_i ? GNT0 : IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit_c) begin
                    state_next = ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (last && !m1_cyc_i) begin
                    state_next = m0_cyc_i ? GNT0 : IDLE;
                end else if (!last && !m0_cyc_i) begin
                    state_next = m1_cyc_i ? GNT1 : IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if ((state_next == GNT0) && (state != GNT0)) begin
            last_next = 1'b0;
        end else if ((state_next == GNT1) && (state != GNT1)) begin
            last_next = 1'b1;
        end
    end

    // Combinational passthrough: slave latency is the response latency.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_cti_o  = 3'b000;
        s_bte_o  = 2'b00;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        if (state != IDLE) begin
            s_adr_o = sel1_c ? m1_adr_i : m0_adr_i;
            s_dat_o = sel1_c ? m1_dat_i : m0_dat_i;
            s_sel_o = sel1_c ? m1_sel_i : m0_sel_i;
            s_we_o  = sel1_c ? m1_we_i  : m0_we_i;
            s_cti_o = sel1_c ? m1_cti_i : m0_cti_i;
            s_bte_o = sel1_c ? m1_bte_i : m0_bte_i;
        end
        if (state == GNT0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i;
            m0_rty_o = s_rty_i;
        end else if (state == GNT1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i;
            m1_rty_o = s_rty_i;
        end
        // Abort: slave side is cut off, owner gets a single err pulse.
        if (abort_err_c) begin
            m0_err_o = ~sel1_c;
            m1_err_o = sel1_c;
        end
    end

endmodule

// File: tb/tb_wb_ext_mem_arbiter.sv
// Directed self-checking bench for wb_ext_mem_arbiter: single read,
// tie alternation with handover, burst ownership, async reset mid-burst,
// retry routing and watchdog (or its absence in the default build).
module tb_wb_ext_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   m0_adr, m1_adr;
    logic [DW-1:0]   m0_wdat, m1_wdat;
    logic [3:0]      m0_sel, m1_sel;
    logic            m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [2:0]      m0_cti, m1_cti;
    logic [1:0]      m0_bte, m1_bte;
    logic [DW-1:0]   m0_rdat, m1_rdat;
    logic            m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat, s_rdat;
    logic [3:0]      s_sel;
    logic            s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic [1:0]      gnt;

    int checks = 0;
    int errors = 0;

    wb_ext_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .gnt_o(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; drives follow here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after a drive before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        m0_adr = '0; m0_wdat = '0; m0_sel = 4'hF; m0_we = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = 3'b000; m0_bte = 2'b00;
        m1_adr = '0; m1_wdat = '0; m1_sel = 4'hF; m1_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'b000; m1_bte = 2'b00;
        s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

        // Reset state
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_scyc", 32'(s_cyc), 32'h0);
        check("rst_m0ack", 32'(m0_ack), 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // m0 single read, slave acks two clocks after grant
        tick();
        m0_adr = 32'h0000_1000; m0_cyc = 1'b1; m0_stb = 1'b1;
        settle();
        check("rd_gnt_req_cycle", 32'(gnt), 32'h0);
        check("rd_scyc_req_cycle", 32'(s_cyc), 32'h0);
        tick();
        check("rd_gnt", 32'(gnt), 32'h1);
        check("rd_scyc", 32'(s_cyc), 32'h1);
        check("rd_sadr", s_adr, 32'h0000_1000);
        check("rd_m0ack_wait", 32'(m0_ack), 32'h0);
        tick(); tick();
        s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        settle();
        check("rd_m0ack", 32'(m0_ack), 32'h1);
        check("rd_m0dat", m0_rdat, 32'hDEAD_BEEF);
        check("rd_m1term", 32'({m1_ack, m1_err, m1_rty}), 32'h0);
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        check("rd_m0ack_once", 32'(m0_ack), 32'h0);
        check("rd_scyc_release", 32'(s_cyc), 32'h0);
        tick();
        check("rd_gnt_idle", 32'(gnt), 32'h0);

        // Tie right after reset goes to m0, then direct handover to m1
        rst_n = 1'b0;
        settle();
        rst_n = 1'b1;
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        m1_adr = 32'h0000_2000;
        tick();
        check("tie_first_gnt", 32'(gnt), 32'h1);
        check("tie_m1_waits_noack", 32'(m1_ack), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        check("handover_scyc_low", 32'(s_cyc), 32'h0);
        tick();
        check("handover_gnt", 32'(gnt), 32'h2);
        check("handover_sadr", s_adr, 32'h0000_2000);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        // Four clean ties alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
            tick();
            check($sformatf("tie%0d_gnt", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            tick();
            check($sformatf("tie%0d_idle", i), 32'(gnt), 32'h0);
        end

        // m1 incrementing burst while m0 requests throughout
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_cti = 3'b010; m1_bte = 2'b00;
        m1_adr = 32'h0000_3000;
        tick();
        check("burst_gnt", 32'(gnt), 32'h2);
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_4000;
        for (int b = 0; b < 4; b++) begin
            m1_cti = (b == 3) ? 3'b111 : 3'b010;
            m1_adr = 32'h0000_3000 + 32'(b * 4);
            s_ack = 1'b1; s_rdat = 32'h1000 + 32'(b);
            settle();
            check($sformatf("burst%0d_m1ack", b), 32'(m1_ack), 32'h1);
            check($sformatf("burst%0d_m0ack", b), 32'(m0_ack), 32'h0);
            check($sformatf("burst%0d_gnt", b), 32'(gnt), 32'h2);
            check($sformatf("burst%0d_cti", b), 32'(s_cti), (b == 3) ? 32'h7 : 32'h2);
            tick();
        end
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'b000;
        settle();
        check("burst_end_gnt", 32'(gnt), 32'h2);
        tick();
        check("burst_m0_gnt", 32'(gnt), 32'h1);
        check("burst_m0_sadr", s_adr, 32'h0000_4000);

        // Reset pulled low mid-burst of m0
        m0_cti = 3'b010;
        s_ack = 1'b1;
        settle();
        check("rstmid_m0ack", 32'(m0_ack), 32'h1);
        s_ack = 1'b0;
        settle();
        rst_n = 1'b0;
        settle();
        check("rstmid_scyc", 32'(s_cyc), 32'h0);
        check("rstmid_gnt", 32'(gnt), 32'h0);
        tick();
        rst_n = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        check("rstmid_regrant", 32'(gnt), 32'h1);
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = 3'b000;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        // Retry to m1 with m0 waiting; last=m0 so the tie goes to m1
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        check("rty_gnt", 32'(gnt), 32'h2);
        s_rty = 1'b1;
        settle();
        check("rty_m1rty", 32'(m1_rty), 32'h1);
        check("rty_m0rty", 32'(m0_rty), 32'h0);
        tick();
        s_rty = 1'b0;
        settle();
        check("rty_m1rty_once", 32'(m1_rty), 32'h0);
        tick();
        check("rty_gnt_held", 32'(gnt), 32'h2);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        check("rty_handover", 32'(gnt), 32'h1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // Slave never acks an m0 write
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_5000;
        tick();
        check("wd_gnt", 32'(gnt), 32'h1);
        check("wd_sstb", 32'(s_stb), 32'h1);
        m1_cyc = 1'b1; m1_stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("wd_wait%0d_err", k), 32'(m0_err), 32'h0);
            check($sformatf("wd_wait%0d_scyc", k), 32'(s_cyc), 32'h1);
        end
        tick();
        check("wd_m0err", 32'(m0_err), 32'h1);
        check("wd_m1err", 32'(m1_err), 32'h0);
        check("wd_abort_scyc", 32'(s_cyc), 32'h0);
        s_ack = 1'b1;
        tick();
        check("wd_err_once", 32'(m0_err), 32'h0);
        check("wd_late_ack_dropped", 32'(m0_ack), 32'h0);
        check("wd_abort_scyc_hold", 32'(s_cyc), 32'h0);
        check("wd_abort_gnt", 32'(gnt), 32'h0);
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        check("wd_m1_gnt", 32'(gnt), 32'h2);
        check("wd_m1_scyc", 32'(s_cyc), 32'h1);
`else
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("wd_none%0d_err", k), 32'(m0_err), 32'h0);
            check($sformatf("wd_none%0d_scyc", k), 32'(s_cyc), 32'h1);
        end
        check("wd_none_gnt", 32'(gnt), 32'h1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        check("wd_none_m1_gnt", 32'(gnt), 32'h2);
`endif
        m1_cyc = 1'b0; m1_stb = 1'b0; m0_we = 1'b0;
        tick();
        check("final_idle", 32'(gnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
